// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if
// Bundles the MEM-stage pipeline controls, the data-cache request/hit
// handshake and the load-data return path between the pipeline and
// mem_stage_ctrl.
//   slave  : used by mem_stage_ctrl (pipeline/cache inputs in, requests out)
//   master : used by the surrounding pipeline/cache model
// Optional macro LLSC_EN adds the load-linked / store-conditional signals.
interface mem_stage_ctrl_if #(
  parameter int WORD_W = 32
);
  typedef logic [WORD_W-1:0] word_t;

  logic  mem_valid;
  logic  MemRead_in;
  logic  MemWrite_in;
  word_t aluOutport_in;
  word_t store_in;
  logic  advance;
  logic  dhit;
  word_t dmemload;
  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  mem_stall;
  word_t dmemload_out;
`ifdef LLSC_EN
  logic  LL_in;
  logic  SC_in;
  logic  snoop_inv;
  word_t snoop_addr;
  word_t sc_result;
`endif

  modport slave (
    input  mem_valid, MemRead_in, MemWrite_in, aluOutport_in, store_in,
    input  advance, dhit, dmemload,
`ifdef LLSC_EN
    input  LL_in, SC_in, snoop_inv, snoop_addr,
    output sc_result,
`endif
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, dmemload_out
  );

  modport master (
    output mem_valid, MemRead_in, MemWrite_in, aluOutport_in, store_in,
    output advance, dhit, dmemload,
`ifdef LLSC_EN
    output LL_in, SC_in, snoop_inv, snoop_addr,
    input  sc_result,
`endif
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, dmemload_out
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// MEM-stage data-memory access controller. Converts the latched
// MemRead/MemWrite controls into a dmemREN/dmemWEN request to the data
// cache, stalls the pipeline until dhit, and returns load data to MEM/WB.
// Ports:
//   CLK  : system clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : mem_stage_ctrl_if.slave (pipeline controls, cache handshake,
//          load data out)
// Optional macro LLSC_EN: adds a link register for LL/SC atomics.
//
// state  | meaning
// IDLE   | no access outstanding; a new instruction may issue
// ACCESS | request issued, waiting for dhit
// HOLD   | access done, pipeline frozen; no re-issue until advance
module mem_stage_ctrl #(
  parameter int WORD_W = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  mem_stage_ctrl_if.slave bus
);
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t state_q, state_d;
  word_t  load_q, load_d;

  logic rd_c, wr_c, op_c, sc_fail_c, req_ok_c;
  logic ren_c, wen_c;

`ifdef LLSC_EN
  logic  link_valid_q, link_valid_d;
  word_t link_addr_q, link_addr_d;
  logic  link_hit_c;
`endif

  // Request decode. A read always wins over a simultaneous write.
  always_comb begin
    rd_c      = bus.MemRead_in;
    wr_c      = bus.MemWrite_in & ~bus.MemRead_in;
    sc_fail_c = 1'b0;
`ifdef LLSC_EN
    link_hit_c = link_valid_q & (bus.aluOutport_in == link_addr_q);
    rd_c       = bus.MemRead_in | bus.LL_in;
    // A failed SC never reaches the cache; it completes locally.
    wr_c       = bus.MemWrite_in & ~rd_c & ~(bus.SC_in & ~link_hit_c);
    sc_fail_c  = bus.mem_valid & bus.SC_in & bus.MemWrite_in & ~rd_c & ~link_hit_c;
`endif
    op_c     = bus.mem_valid & (rd_c | wr_c);
    // Requests are suppressed in HOLD and while reset is held.
    req_ok_c = nRST & (state_q != HOLD);
    ren_c    = rd_c & op_c & req_ok_c;
    wen_c    = wr_c & op_c & req_ok_c;
  end

  assign bus.dmemREN      = ren_c;
  assign bus.dmemWEN      = wen_c;
  assign bus.dmemaddr     = bus.aluOutport_in;
  assign bus.dmemstore    = bus.store_in;
  assign bus.mem_stall    = op_c & ~bus.dhit & req_ok_c;
  assign bus.dmemload_out = (bus.dhit & ren_c) ? bus.dmemload : load_q;

`ifdef LLSC_EN
  assign bus.sc_result = word_t'(bus.mem_valid & bus.SC_in & link_hit_c);
`endif

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    if (bus.dhit & ren_c) load_d = bus.dmemload;
    unique case (state_q)
      IDLE: begin
        if (op_c & ~bus.dhit)
          state_d = ACCESS;
        else if (((op_c & bus.dhit) | sc_fail_c) & ~bus.advance)
          state_d = HOLD;
      end
      ACCESS: begin
        // Flush (bubble) aborts the access outright.
        if (~op_c)
          state_d = IDLE;
        else if (bus.dhit)
          state_d = bus.advance ? IDLE : HOLD;
      end
      HOLD: begin
        if (bus.advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end

`ifdef LLSC_EN
  // Clears take precedence over a same-cycle LL link set.
  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (bus.dhit & ren_c & bus.LL_in) begin
      link_valid_d = 1'b1;
      link_addr_d  = bus.aluOutport_in;
    end
    if (bus.dhit & wen_c & (bus.aluOutport_in == link_addr_q))
      link_valid_d = 1'b0;
    if (bus.snoop_inv & (bus.snoop_addr == link_addr_q))
      link_valid_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end
`endif
endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
  logic CLK;
  logic nRST;
  int   checks = 0;
  int   errors = 0;

  mem_stage_ctrl_if #(.WORD_W(32)) bus ();

  mem_stage_ctrl #(.WORD_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        mv, rd, wr, adv, dhit;
    logic [31:0] addr, store, load;
    logic        exp_ren, exp_wen, exp_stall;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic rd, input logic wr, input logic adv,
                       input logic dhit, input logic [31:0] addr, input logic [31:0] store,
                       input logic [31:0] load);
    bus.mem_valid     = mv;
    bus.MemRead_in    = rd;
    bus.MemWrite_in   = wr;
    bus.advance       = adv;
    bus.dhit          = dhit;
    bus.aluOutport_in = addr;
    bus.store_in      = store;
    bus.dmemload      = load;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int stall_n;
    int wen_n;

    //             name        mv rd wr adv dh addr   store         load          ren wen st out
    vecs[0] = '{"load_hit",    1, 1, 0, 1, 1, 32'h40, 32'h0,        32'hDEADBEEF, 1, 0, 0, 32'hDEADBEEF};
    vecs[1] = '{"bubble",      0, 1, 0, 1, 1, 32'h44, 32'h0,        32'h11111111, 0, 0, 0, 32'hDEADBEEF};
    vecs[2] = '{"store_hit",   1, 0, 1, 1, 1, 32'h80, 32'h12345678, 32'h22222222, 0, 1, 0, 32'hDEADBEEF};
    vecs[3] = '{"rd_wr_both",  1, 1, 1, 1, 1, 32'h84, 32'hAAAA5555, 32'hCAFEF00D, 1, 0, 0, 32'hCAFEF00D};
    vecs[4] = '{"no_memop",    1, 0, 0, 1, 0, 32'h88, 32'h0,        32'h33333333, 0, 0, 0, 32'hCAFEF00D};
    vecs[5] = '{"bubble_wr",   0, 0, 1, 1, 0, 32'h8C, 32'h5,        32'h44444444, 0, 0, 0, 32'hCAFEF00D};

`ifdef LLSC_EN
    bus.LL_in = 0; bus.SC_in = 0; bus.snoop_inv = 0; bus.snoop_addr = '0;
`endif

    // Reset state: a load is presented but reset holds requests off.
    nRST = 1'b0;
    drive(1, 1, 0, 1, 1, 32'h1234, 32'h5678, 32'h99999999);
    #3;
    check("rst_ren",   32'(bus.dmemREN), 32'd0);
    check("rst_wen",   32'(bus.dmemWEN), 32'd0);
    check("rst_stall", 32'(bus.mem_stall), 32'd0);
    check("rst_out",   bus.dmemload_out, 32'h0);
    check("rst_addr",  bus.dmemaddr, 32'h1234);
    check("rst_store", bus.dmemstore, 32'h5678);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;

    // Single-cycle vectors, each leaves the FSM in IDLE.
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(vecs[i].mv, vecs[i].rd, vecs[i].wr, vecs[i].adv, vecs[i].dhit,
            vecs[i].addr, vecs[i].store, vecs[i].load);
      #2;
      check({vecs[i].name, "_ren"},   32'(bus.dmemREN),   32'(vecs[i].exp_ren));
      check({vecs[i].name, "_wen"},   32'(bus.dmemWEN),   32'(vecs[i].exp_wen));
      check({vecs[i].name, "_stall"}, 32'(bus.mem_stall), 32'(vecs[i].exp_stall));
      check({vecs[i].name, "_out"},   bus.dmemload_out,   vecs[i].exp_out);
      check({vecs[i].name, "_addr"},  bus.dmemaddr,       vecs[i].addr);
      check({vecs[i].name, "_store"}, bus.dmemstore,      vecs[i].store);
    end

    // Store with a 3-cycle miss: 3 stall cycles, 4 write-request cycles.
    tick();
    drive(1, 0, 1, 0, 0, 32'h80, 32'h12345678, 32'h0);
    stall_n = 0;
    wen_n   = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      if (c == 3) begin
        bus.dhit    = 1'b1;
        bus.advance = 1'b1;
      end
      #2;
      stall_n += int'(bus.mem_stall);
      wen_n   += int'(bus.dmemWEN);
      check("miss_addr", bus.dmemaddr, 32'h80);
    end
    check("miss_stall_cycles", 32'(stall_n), 32'd3);
    check("miss_wen_cycles",   32'(wen_n),   32'd4);
    tick();
    drive(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);
    #2;
    check("store_no_capture", bus.dmemload_out, 32'hCAFEF00D);

    // Load hits under an external stall: HOLD for 2 cycles, no re-issue.
    tick();
    drive(1, 1, 0, 0, 1, 32'h44, 32'h0, 32'hA5A5A5A5);
    #2;
    check("hold_first_ren", 32'(bus.dmemREN), 32'd1);
    check("hold_first_out", bus.dmemload_out, 32'hA5A5A5A5);
    for (int c = 0; c < 2; c++) begin
      tick();
      bus.dhit     = 1'b0;
      bus.dmemload = 32'hFFFF0000;
      #2;
      check("hold_ren",   32'(bus.dmemREN),   32'd0);
      check("hold_stall", 32'(bus.mem_stall), 32'd0);
      check("hold_out",   bus.dmemload_out,   32'hA5A5A5A5);
    end
    tick();
    bus.advance = 1'b1;
    #2;
    check("hold_release_ren", 32'(bus.dmemREN), 32'd0);
    tick();
    drive(1, 1, 0, 1, 1, 32'h48, 32'h0, 32'h0BADC0DE);
    #2;
    check("after_hold_ren", 32'(bus.dmemREN), 32'd1);
    check("after_hold_out", bus.dmemload_out, 32'h0BADC0DE);

    // Miss then hit while stalled: ACCESS -> HOLD.
    tick();
    drive(1, 1, 0, 0, 0, 32'h4C, 32'h0, 32'h0);
    tick();
    bus.dhit     = 1'b1;
    bus.dmemload = 32'h600DF00D;
    #2;
    check("acc_hit_ren", 32'(bus.dmemREN), 32'd1);
    tick();
    bus.dhit = 1'b0;
    #2;
    check("acc_hold_ren", 32'(bus.dmemREN), 32'd0);
    check("acc_hold_out", bus.dmemload_out, 32'h600DF00D);
    tick();
    bus.advance = 1'b1;
    tick();
    drive(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);

    // Reset asserted mid-access.
    tick();
    drive(1, 1, 0, 0, 0, 32'h60, 32'h0, 32'h77777777);
    tick();
    #1;
    check("acc_stall", 32'(bus.mem_stall), 32'd1);
    nRST = 1'b0;
    #1;
    check("midrst_ren",   32'(bus.dmemREN),   32'd0);
    check("midrst_stall", 32'(bus.mem_stall), 32'd0);
    check("midrst_out",   bus.dmemload_out,   32'h0);
    nRST = 1'b1;
    #1;
    check("rst_reissue_ren",   32'(bus.dmemREN),   32'd1);
    check("rst_reissue_stall", 32'(bus.mem_stall), 32'd1);
    tick();
    bus.dhit    = 1'b1;
    bus.advance = 1'b1;
    #2;
    check("rst_done_out", bus.dmemload_out, 32'h77777777);
    tick();
    drive(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);

    // Flush while in ACCESS.
    tick();
    drive(1, 1, 0, 0, 0, 32'h90, 32'h0, 32'h0);
    tick();
    bus.mem_valid = 1'b0;
    #2;
    check("flush_ren",   32'(bus.dmemREN),   32'd0);
    check("flush_stall", 32'(bus.mem_stall), 32'd0);
    tick();
    drive(1, 1, 0, 1, 1, 32'h94, 32'h0, 32'h13579BDF);
    #2;
    check("post_flush_ren", 32'(bus.dmemREN), 32'd1);
    check("post_flush_out", bus.dmemload_out, 32'h13579BDF);
    tick();
    drive(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);

`ifdef LLSC_EN
    // LL then SC to the same address succeeds.
    tick();
    drive(1, 1, 0, 1, 1, 32'h100, 32'h0, 32'h1);
    bus.LL_in = 1'b1;
    tick();
    bus.LL_in = 1'b0;
    drive(1, 0, 1, 1, 1, 32'h100, 32'hABCD, 32'h0);
    bus.SC_in = 1'b1;
    #2;
    check("sc_ok_wen", 32'(bus.dmemWEN), 32'd1);
    check("sc_ok_res", bus.sc_result, 32'd1);
    tick();
    bus.SC_in = 1'b0;
    drive(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);
    // LL, snoop invalidate, SC fails.
    tick();
    drive(1, 1, 0, 1, 1, 32'h100, 32'h0, 32'h2);
    bus.LL_in = 1'b1;
    tick();
    bus.LL_in = 1'b0;
    drive(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);
    bus.snoop_inv  = 1'b1;
    bus.snoop_addr = 32'h100;
    tick();
    bus.snoop_inv = 1'b0;
    drive(1, 0, 1, 1, 0, 32'h100, 32'hABCD, 32'h0);
    bus.SC_in = 1'b1;
    #2;
    check("sc_fail_wen",   32'(bus.dmemWEN),   32'd0);
    check("sc_fail_stall", 32'(bus.mem_stall), 32'd0);
    check("sc_fail_res",   bus.sc_result,      32'd0);
    tick();
    bus.SC_in = 1'b0;
    drive(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Data-memory access controller for the MEM stage of the pipelined datapath. It sits between the EX/MEM latch and the MEM/WB latch. It turns the latched MemRead/MemWrite controls into a request/hit handshake with the data cache and holds the pipeline until the access completes. It then presents the load word to the MEM/WB latch's `dmemload_in`.

## Interface
Parameters:
- `WORD_W`, 32: data and address width (`word_t`).

Ports:
- `CLK` in 1: system clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `mem_valid` in 1: EX/MEM holds a valid (non-bubble) instruction.
- `MemRead_in` in 1: load.
- `MemWrite_in` in 1: store.
- `aluOutport_in` in 32: effective address.
- `store_in` in 32: store data (rt value).
- `advance` in 1: all pipeline latches capture this cycle.
- `dhit` in 1: cache completed the current request.
- `dmemload` in 32: cache read data, valid with `dhit`.
- `dmemREN` out 1: read request to the cache.
- `dmemWEN` out 1: write request to the cache.
- `dmemaddr` out 32: request address.
- `dmemstore` out 32: write data.
- `mem_stall` out 1: MEM access outstanding; the hazard unit must hold `advance` low.
- `dmemload_out` out 32: load data to MEM/WB.

## Operation
- States: IDLE, ACCESS, HOLD. Reset state is IDLE.
- `op = mem_valid & (MemRead_in | MemWrite_in)`.
- `MemRead_in` and `MemWrite_in` both high is illegal. Read takes priority and the write is dropped.
- **Request:** `dmemREN = MemRead_in & op`, `dmemWEN = MemWrite_in & op & ~MemRead_in`, qualified by state ∈ {IDLE, ACCESS}. Both are 0 in HOLD.
- `dmemaddr = aluOutport_in` and `dmemstore = store_in`, both combinational.
- `mem_stall = op & ~dhit & state≠HOLD`.
- **Transitions:**
  - IDLE: if `op & ~dhit`, go to ACCESS. If `op & dhit & ~advance`, go to HOLD. Otherwise stay in IDLE.
  - ACCESS: if `dhit & advance`, go to IDLE. If `dhit & ~advance`, go to HOLD. Otherwise stay in ACCESS.
  - HOLD: on `advance`, go to IDLE.
- The HOLD state guarantees exactly one cache transaction per instruction, even while the latch stays frozen by an unrelated stall.
- **Load data:** `load_q` captures `dmemload` on `dhit & dmemREN`. `dmemload_out = (dhit & dmemREN) ? dmemload : load_q`.
- **Bubble:** when `mem_valid=0` in ACCESS, abort and return to IDLE. Requests drop the same cycle.
- **Reset mid-access:** return to IDLE immediately, clear `load_q` to 0, and deassert requests while `nRST=0`.

## Timing
- Zero-cycle request issue: requests assert combinationally in the same cycle the instruction is present in EX/MEM.
- Best-case latency is 0 extra cycles: `dhit` in the first cycle means no stall.
- An N-cycle miss gives N `mem_stall` cycles.
- Reset values:
  - `load_q` = 0.
  - `dmemREN` = 0, `dmemWEN` = 0, `mem_stall` = 0.
  - `dmemaddr` and `dmemstore` follow their inputs.
  - `dmemload_out` = 0.
- The state register and `load_q` update on the rising edge of `CLK`.

## Configuration
- **`LLSC_EN` defined:**
  - Adds inputs `LL_in` (1), `SC_in` (1), `snoop_inv` (1) and `snoop_addr` (32), plus output `sc_result` (32).
  - Adds a link register `{link_valid, link_addr}`, reset to 0.
  - LL behaves as a load. On its `dhit`, it sets `link_valid=1` and `link_addr=aluOutport_in`.
  - **SC with link hit** (`link_valid` and address match): behaves as a store, `sc_result=1`, and `link_valid` clears on `dhit`.
  - **SC with link miss:** no request is issued, `mem_stall=0`, `sc_result=0`, and the FSM goes to HOLD unless `advance` is high.
  - **Link clears when:**
    - any completed store matches `link_addr`,
    - `snoop_inv` is high and `snoop_addr==link_addr`, or
    - reset occurs.
- **`LLSC_EN` undefined:** none of these ports or the link register exist, and `sc_result` is absent.

## Test plan
- Load at 0x0000_0040, `dhit` in the same cycle, `advance=1`:
  - `mem_stall` stays 0, `dmemREN` pulses 1 cycle, `dmemload_out=dmemload` (0xDEAD_BEEF), FSM stays IDLE.
- Store of 0x1234_5678 to 0x80 with `dhit` after 3 cycles:
  - `mem_stall=1` for 3 cycles, `dmemWEN` is held for 4 cycles, `dmemaddr=0x80` throughout.
- Load hits while `advance=0` for 2 more cycles (external stall):
  - FSM goes to HOLD, `dmemREN=0` for those 2 cycles, `dmemload_out=load_q` holds the value, no second request.
- `nRST` asserted during ACCESS:
  - requests drop immediately, `load_q=0`, and after release the FSM is IDLE and reissues if `op` is still present.
- `mem_valid` drops (flush) while in ACCESS:
  - requests are 0 in that cycle, FSM goes to IDLE, `mem_stall=0`.
- With `LLSC_EN`:
  - LL 0x100, then SC 0x100 gives `sc_result=1` and a write is issued.
  - LL 0x100, `snoop_inv` at 0x100, then SC gives `sc_result=0` and no `dmemWEN`.
